clk_mon: RTL and testbench
==========================

# clk_mon

Clock/strobe monitor for the top-level simulation and bring-up path. It is the receiving end of a generated clock. It samples an asynchronous periodic signal `mon_in` in the `clk` domain and measures its period and high time in `clk` cycles. It checks each measured period against a window, and reports lock, loss-of-signal and a running edge count. It is synthesizable and is also instantiated in the top-level bench to check derived clocks.

## Interface

**Parameters**
- `CNT_W`, 16: width of the period, high-time and edge counters.
- `PER_MIN`, 4: smallest acceptable period, in `clk` cycles.
- `PER_MAX`, 4: largest acceptable period, in `clk` cycles.
- `TIMEOUT`, 1024: `clk` cycles without a rising edge before loss is declared. Must be ≤ 2^CNT_W−1.
- `LOCK_CNT`, 4: number of consecutive in-window periods required for lock.

**Ports**
- `clk` input 1: single clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: monitor enable (level).
- `mon_in` input 1: monitored signal, asynchronous to `clk`.
- `period` output CNT_W: last measured period, in cycles. Reset value 0.
- `high_time` output CNT_W: high cycles within the last period. Reset value 0.
- `meas_valid` output 1: one-cycle pulse when `period`/`high_time` update. Reset value 0.
- `period_err` output 1: one-cycle pulse, coincident with `meas_valid`, when the period is out of window. Reset value 0.
- `locked` output 1: level. Reset value 0.
- `lost` output 1: level. Reset value 0.
- `edge_cnt` output CNT_W: count of detected rising edges while enabled, saturating. Reset value 0.

## Operation

**Input conditioning**
- 2-flop synchronizer `s1`→`s2`, followed by delay flop `s3`. These run regardless of `en`; all three reset to 0.
- `rise = s2 & ~s3`.

**Counters**
- `per_cnt`
  - On `rise`: loaded with 1.
  - Otherwise: incremented, saturating at 2^CNT_W−1.
- `high_cnt`
  - On `rise`: loaded with 1.
  - Otherwise: incremented while `s2`=1, held while `s2`=0. Saturates.

**State machine** (`IDLE`, `WAIT_FIRST`, `MEASURE`, `LOST`; reset state is `IDLE`)
- `IDLE`
  - `per_cnt`, `high_cnt` and the good-period counter are cleared.
  - `locked`=0, `lost`=0. `period` and `high_time` hold their values.
  - `en`=1 → `WAIT_FIRST`.
- `WAIT_FIRST`
  - `rise` → `MEASURE`. The counters start; no `meas_valid`.
  - `per_cnt`==TIMEOUT without a rise → `LOST`.
- `MEASURE`
  - `rise`: `period`←`per_cnt`, `high_time`←`high_cnt`, `meas_valid`=1.
  - `period_err`=1 if `per_cnt` < PER_MIN or `per_cnt` > PER_MAX.
  - `per_cnt`==TIMEOUT → `LOST`.
- `LOST`
  - `lost`=1, `locked`=0, good-period counter cleared.
  - `rise` → `MEASURE`, `lost`←0. No `meas_valid` on this rise; it restarts the measurement.
- From any state, `en`=0 → `IDLE` on the next edge.

**Lock**
- The good-period counter increments on each `meas_valid` without `period_err`, saturating at LOCK_CNT.
- `locked`=1 when the counter reaches LOCK_CNT.
- Any `period_err` clears the counter and `locked` on the same edge that issues the pulse.

**Edge count**
- `edge_cnt` increments on every `rise` while `en`=1, in every non-`IDLE` state, including the rise that exits `WAIT_FIRST` or `LOST`.
- Saturates at 2^CNT_W−1. Cleared only by `rst`.

**Simultaneous events**
- `rise` and `per_cnt`==TIMEOUT in the same cycle: the rise wins and the timeout is ignored.
- `en` falling in a cycle with `rise`: the `en`=0 transition takes priority. No `meas_valid` is issued and `edge_cnt` does not increment.

**Enable and reset**
- Re-enabling while `mon_in` is high causes no false rise, because the synchronizer kept running while disabled.
- `rst` mid-operation: all flops return to their reset values on that edge.

## Timing

- Let N be the first `clk` edge that samples `mon_in`=1. Then `s1`=1 after N, `s2`=1 after N+1, and `rise` is true between N+1 and N+2.
- `meas_valid` is visible in the cycle after edge N+2. Detection latency is therefore 3 edges.
- Measurement definitions:
  - `period` = number of `clk` cycles between consecutive detected rises.
  - `high_time` = number of cycles `s2` was high in that period.
- Both quantities are quantized to ±1 `clk` cycle because `mon_in` is asynchronous.
- `meas_valid` and `period_err` are never high for two consecutive cycles, unless `period`==1. That case is not supported; PER_MIN ≥ 2.
- `lost` asserts in the cycle after `per_cnt` reaches TIMEOUT.

## Test plan

- **Steady input:** `clk` 4 ns period, `mon_in` 16 ns period at 50% duty, `en`=1.
  - First rise: no `meas_valid`.
  - Every later rise: `period`=4, `high_time`=2, `period_err`=0.
  - `locked`=1 after the 4th valid measurement.
- **Out-of-window period:** switch `mon_in` to a 20 ns period.
  - Next measurement: `period`=5, `period_err`=1, `locked`→0.
  - Back at 16 ns: `locked` reasserts after 4 good periods.
- **Loss and recovery:** hold `mon_in` low.
  - `lost`=1 exactly TIMEOUT cycles after the last rise, plus 1; `locked`=0.
  - Restart `mon_in`: `lost`→0 on the first rise, first `meas_valid` on the second rise.
- **Disable mid-operation:** drop `en` while locked.
  - Next cycle: `locked`=0, `lost`=0, `meas_valid`=0. `period` holds 4 and `edge_cnt` freezes.
  - Re-assert `en` with `mon_in` high: no immediate rise or `meas_valid`.
- **Reset mid-operation:** assert `rst` for 1 cycle during `MEASURE`.
  - All outputs read 0 the next cycle.
  - Measurement resumes through `WAIT_FIRST`.
- **Saturation:** CNT_W=4, TIMEOUT=15, `mon_in` at 20 cycles with a 2-cycle high pulse. Check that `edge_cnt` and `per_cnt` saturate at 15 without wrapping.
  - `lost` asserts each period.
  - Each rise recovers to `MEASURE`; `meas_valid` never fires.

Source files
------------

// File: rtl/clk_mon.sv
// clk_mon: measures period and high time of an asynchronous periodic input in clk cycles,
// checks the period against a window and reports lock, loss-of-signal and a rising-edge count.
module clk_mon #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PER_MIN  = 4,
  parameter int unsigned PER_MAX  = 4,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             period_err,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PerMinV  = CNT_W'(PER_MIN);
  localparam logic [CNT_W-1:0]  PerMaxV  = CNT_W'(PER_MAX);
  localparam logic [CNT_W-1:0]  TimeoutV = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GoodMax  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GoodOne  = GOOD_W'(1);

  typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure, StLost} state_t;

  state_t            state;
  logic              s1, s2, s3;
  logic              rise;
  logic [CNT_W-1:0]  per_cnt, high_cnt;
  logic [CNT_W-1:0]  per_inc, high_inc, edge_inc;
  logic [GOOD_W-1:0] good_cnt, good_inc;
  logic              in_window, timeout_hit;

  // Edge detect, saturating increments and window/timeout decodes.
  always_comb begin
    rise        = s2 & ~s3;
    per_inc     = (per_cnt == CntMax) ? per_cnt : per_cnt + CntOne;
    high_inc    = (high_cnt == CntMax) ? high_cnt : high_cnt + CntOne;
    edge_inc    = (edge_cnt == CntMax) ? edge_cnt : edge_cnt + CntOne;
    good_inc    = (good_cnt >= GoodMax) ? GoodMax : good_cnt + GoodOne;
    in_window   = (per_cnt >= PerMinV) && (per_cnt <= PerMaxV);
    timeout_hit = (per_cnt == TimeoutV);
  end

  // Synchronizer, counters, monitor FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      per_cnt    <= '0;
      high_cnt   <= '0;
      good_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      locked     <= 1'b0;
      lost       <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      // The synchronizer runs while disabled so re-enabling on a high input sees no edge.
      s1         <= mon_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      if (!en) begin
        // Disable overrides everything, including a rise in the same cycle.
        state    <= StIdle;
        per_cnt  <= '0;
        high_cnt <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        lost     <= 1'b0;
      end else if (state == StIdle) begin
        state    <= StWaitFirst;
        per_cnt  <= '0;
        high_cnt <= '0;
        good_cnt <= '0;
      end else begin
        if (rise) begin
          per_cnt  <= CntOne;
          high_cnt <= CntOne;
          edge_cnt <= edge_inc;
        end else begin
          per_cnt <= per_inc;
          if (s2) high_cnt <= high_inc;
        end
        case (state)
          StWaitFirst: begin
            if (rise) begin
              state <= StMeasure;
            end else if (timeout_hit) begin
              state <= StLost;
              lost  <= 1'b1;
            end
          end
          StMeasure: begin
            // A rise always wins over a coincident timeout.
            if (rise) begin
              period     <= per_cnt;
              high_time  <= high_cnt;
              meas_valid <= 1'b1;
              if (!in_window) begin
                period_err <= 1'b1;
                good_cnt   <= '0;
                locked     <= 1'b0;
              end else begin
                good_cnt <= good_inc;
                locked   <= (good_inc == GoodMax);
              end
            end else if (timeout_hit) begin
              state    <= StLost;
              lost     <= 1'b1;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end
          StLost: begin
            // This rise only re-arms the measurement; no result is reported.
            if (rise) begin
              state <= StMeasure;
              lost  <= 1'b0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_mon.sv
// Self-checking bench for clk_mon: table-driven steady-input phases, hand-written corner
// sequences, a randomized run against a behavioural model, and a saturation instance.
module tb_clk_mon;

  localparam int unsigned W    = 16;
  localparam int unsigned PMIN = 4;
  localparam int unsigned PMAX = 4;
  localparam int unsigned TO   = 64;
  localparam int unsigned LOCK = 4;
  localparam int          MAXV = 65535;
  localparam int unsigned SW   = 4;
  localparam int unsigned STO  = 15;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic         rst, en, mon_in;
  logic [W-1:0] period, high_time, edge_cnt;
  logic         meas_valid, period_err, locked, lost;

  logic          rst_s, en_s, mon_s;
  logic [SW-1:0] period_s, high_s, edges_s;
  logic          mv_s, err_s, locked_s, lost_s;

  clk_mon #(
    .CNT_W(W), .PER_MIN(PMIN), .PER_MAX(PMAX), .TIMEOUT(TO), .LOCK_CNT(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mon_in(mon_in), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .period_err(period_err), .locked(locked), .lost(lost),
    .edge_cnt(edge_cnt)
  );

  clk_mon #(
    .CNT_W(SW), .PER_MIN(4), .PER_MAX(4), .TIMEOUT(STO), .LOCK_CNT(4)
  ) dut_sat (
    .clk(clk), .rst(rst_s), .en(en_s), .mon_in(mon_s), .period(period_s), .high_time(high_s),
    .meas_valid(mv_s), .period_err(err_s), .locked(locked_s), .lost(lost_s), .edge_cnt(edges_s)
  );

  int total = 0, bad = 0;
  int mv_n, err_n, orphan, last_p, last_h, sent;
  int mv_s_n, err_s_n, lost_s_rises;
  logic lost_s_prev;
  bit chk;

  // Behavioural model: time since the reference rise and synced-high cycles since then.
  bit m_s1, m_s2, m_s3, m_active, m_ref, m_lost, m_locked, m_mv, m_err;
  int m_since, m_highs, m_good, m_edges, m_period, m_high;

  function automatic int sat(int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit r;
    r = m_s2 & ~m_s3;
    m_mv = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_active = 0; m_ref = 0; m_lost = 0; m_locked = 0; m_good = 0;
      m_since = 0; m_highs = 0; m_edges = 0; m_period = 0; m_high = 0;
    end else if (!en) begin
      m_active = 0; m_ref = 0; m_lost = 0; m_locked = 0; m_good = 0;
      m_since = 0; m_highs = 0;
    end else if (!m_active) begin
      m_active = 1; m_ref = 0; m_since = 0; m_highs = 0;
    end else if (r) begin
      m_edges = sat(m_edges + 1);
      if (m_ref) begin
        m_period = sat(m_since);
        m_high   = sat(m_highs);
        m_mv     = 1'b1;
        m_err    = (m_period < int'(PMIN)) || (m_period > int'(PMAX));
        if (m_err) m_good = 0;
        else if (m_good < int'(LOCK)) m_good++;
        m_locked = (m_good == int'(LOCK));
      end
      m_ref = 1; m_lost = 0; m_since = 1; m_highs = 1;
    end else begin
      if (!m_lost && sat(m_since) == int'(TO)) begin
        m_lost = 1; m_locked = 0; m_good = 0; m_ref = 0;
      end
      m_since++;
      m_highs += int'(m_s2);
    end
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = mon_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (meas_valid) begin
      mv_n++;
      last_p = int'(period);
      last_h = int'(high_time);
      if (period_err) err_n++;
    end
    if (period_err && !meas_valid) orphan++;
    if (mv_s) mv_s_n++;
    if (err_s) err_s_n++;
    if (lost_s && !lost_s_prev) lost_s_rises++;
    lost_s_prev = lost_s;
    if (chk) begin
      check("model_period", period, m_period);
      check("model_high_time", high_time, m_high);
      check("model_meas_valid", meas_valid, m_mv);
      check("model_period_err", period_err, m_err);
      check("model_locked", locked, m_locked);
      check("model_lost", lost, m_lost);
      check("model_edge_cnt", edge_cnt, m_edges);
    end
  endtask

  task automatic clear_stats();
    mv_n = 0;
    err_n = 0;
  endtask

  task automatic drive_wave(int p, int h, int n, bit cnt);
    for (int i = 0; i < n; i++) begin
      mon_in = 1'b1;
      if (cnt) sent++;
      repeat (h) tick();
      mon_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_period_err"}, period_err, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_lost"}, lost, 0);
    check({tag, "_edge_cnt"}, edge_cnt, 0);
  endtask

  typedef struct {
    int per;
    int hi;
    int n;
    int exp_mv;
    int exp_err;
    int exp_period;
    int exp_high;
    int exp_locked;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   saved;
    vecs[0] = '{per: 4, hi: 2, n: 6, exp_mv: 5, exp_err: 0, exp_period: 4, exp_high: 2,
                exp_locked: 1};
    vecs[1] = '{per: 5, hi: 2, n: 2, exp_mv: 2, exp_err: 1, exp_period: 5, exp_high: 2,
                exp_locked: 0};
    vecs[2] = '{per: 4, hi: 2, n: 5, exp_mv: 5, exp_err: 1, exp_period: 4, exp_high: 2,
                exp_locked: 1};
    vecs[3] = '{per: 4, hi: 1, n: 3, exp_mv: 3, exp_err: 0, exp_period: 4, exp_high: 1,
                exp_locked: 1};
    vecs[4] = '{per: 3, hi: 1, n: 3, exp_mv: 3, exp_err: 2, exp_period: 3, exp_high: 1,
                exp_locked: 0};
    vecs[5] = '{per: 6, hi: 3, n: 2, exp_mv: 2, exp_err: 2, exp_period: 6, exp_high: 3,
                exp_locked: 0};
    vecs[6] = '{per: 4, hi: 2, n: 6, exp_mv: 6, exp_err: 1, exp_period: 4, exp_high: 2,
                exp_locked: 1};

    rst = 1'b1; en = 1'b0; mon_in = 1'b0;
    rst_s = 1'b1; en_s = 1'b0; mon_s = 1'b0;
    chk = 1'b0; orphan = 0; sent = 0; last_p = 0; last_h = 0;
    mv_s_n = 0; err_s_n = 0; lost_s_rises = 0; lost_s_prev = 1'b0;
    clear_stats();

    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    rst_s = 1'b0;
    tick();

    // Steady-input phases.
    en = 1'b1;
    tick();
    for (int v = 0; v < 7; v++) begin
      clear_stats();
      drive_wave(vecs[v].per, vecs[v].hi, vecs[v].n, 1'b1);
      check($sformatf("vec%0d_meas_count", v), mv_n, vecs[v].exp_mv);
      check($sformatf("vec%0d_err_count", v), err_n, vecs[v].exp_err);
      check($sformatf("vec%0d_period", v), last_p, vecs[v].exp_period);
      check($sformatf("vec%0d_high_time", v), last_h, vecs[v].exp_high);
      check($sformatf("vec%0d_locked", v), locked, vecs[v].exp_locked);
    end

    // Loss: lost rises TO+2 edges after the edge that first sampled the last high.
    repeat (TO - 2) tick();
    check("loss_not_yet", lost, 0);
    tick();
    check("loss_asserted", lost, 1);
    check("loss_unlocked", locked, 0);

    clear_stats();
    drive_wave(4, 2, 1, 1'b1);
    check("recover_lost_clear", lost, 0);
    check("recover_no_meas", mv_n, 0);
    clear_stats();
    drive_wave(4, 2, 1, 1'b1);
    check("recover_first_meas", mv_n, 1);
    check("recover_period", last_p, 4);
    check("recover_high", last_h, 2);

    drive_wave(4, 2, 5, 1'b1);
    check("relock", locked, 1);
    check("edge_count", edge_cnt, sent);

    // Disable in the same cycle as a rise.
    clear_stats();
    mon_in = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    check("dis_no_meas", mv_n, 0);
    check("dis_locked", locked, 0);
    check("dis_lost", lost, 0);
    check("dis_period_hold", period, 4);
    check("dis_edge_freeze", edge_cnt, sent);
    tick();
    mon_in = 1'b0;
    repeat (2) tick();
    drive_wave(4, 2, 2, 1'b0);
    check("dis_pulses_no_meas", mv_n, 0);
    check("dis_pulses_edge", edge_cnt, sent);

    // Re-enable with the input already high.
    mon_in = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    repeat (4) tick();
    check("reen_high_no_meas", mv_n, 0);
    check("reen_high_edge", edge_cnt, sent);
    mon_in = 1'b0;
    repeat (2) tick();
    clear_stats();
    drive_wave(4, 2, 3, 1'b1);
    check("reen_meas_count", mv_n, 2);
    check("reen_period", last_p, 4);
    check("reen_edge", edge_cnt, sent);

    // Reset during measurement.
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    sent = 0;
    clear_stats();
    drive_wave(4, 2, 3, 1'b1);
    check("midrst_meas_count", mv_n, 2);
    check("midrst_period", last_p, 4);
    check("midrst_high", last_h, 2);
    check("midrst_edge", edge_cnt, 3);
    check("err_without_valid", orphan, 0);

    // Randomized run against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    chk = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int r, p, h;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        if ($urandom_range(0, 1) == 1) mon_in = 1'b1;
        repeat (3) tick();
        en = 1'b1;
      end else if (r == 1) begin
        mon_in = 1'b0;
        repeat (TO + 6) tick();
      end else begin
        p = int'($urandom_range(2, 9));
        h = int'($urandom_range(1, p - 1));
        drive_wave(p, h, int'($urandom_range(1, 4)), 1'b0);
      end
    end
    chk = 1'b0;

    // Saturation instance: 20-cycle period, 2-cycle pulse, timeout 15.
    en_s = 1'b1;
    tick();
    lost_s_rises = 0;
    mv_s_n = 0;
    err_s_n = 0;
    for (int k = 0; k < 18; k++) begin
      mon_s = 1'b1;
      repeat (2) tick();
      mon_s = 1'b0;
      repeat (18) tick();
      if (k == 13) check("sat_edge_14", edges_s, 14);
    end
    check("sat_edge_hold", edges_s, 15);
    check("sat_lost_each_period", lost_s_rises, 18);
    check("sat_lost_level", lost_s, 1);
    check("sat_no_meas", mv_s_n, 0);
    check("sat_no_err", err_s_n, 0);
    check("sat_period_reset_val", period_s, 0);
    check("sat_high_reset_val", high_s, 0);
    check("sat_unlocked", locked_s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
